// File: rtl/evo_servo_multi_pkg.sv
// evo_servo_multi_pkg: register map, CTRL bit positions and pulse-width clamp for evo_servo_multi.
package evo_servo_multi_pkg;
    localparam int CTRL_OFS    = 0;
    localparam int PW_L_OFS    = 2;
    localparam int PW_H_OFS    = 3;
    localparam int CH_CTRL_OFS = 4;
    localparam int CH_STRIDE   = 3;
    localparam int CTRL_GEN    = 0;
    localparam int CTRL_DONE   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CNT_W       = 16;

    function automatic logic [15:0] clamp(input logic [15:0] v, input logic [15:0] lo, input logic [15:0] hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction
endpackage

// File: rtl/evo_xb_addr_pkg.sv
// evo_xb_addr_pkg: CSR base addresses of the OpenEvo XB peripherals.
package evo_xb_addr_pkg;
    localparam logic [11:0] EVO_SERVO_MULTI_ADDR = 12'h8B0;
endpackage

// File: rtl/evo_servo_chan.sv
// evo_servo_chan: one servo channel -- PW temp/shadow/active registers, frame compare and output flop.
// OFS_US is the channel's rise point in the frame; widths are compared modulo FRAME_US from there.
module evo_servo_chan
    import evo_servo_multi_pkg::*;
#(
    parameter int MIN_US   = 500,
    parameter int MAX_US   = 2500,
    parameter int RESET_US = 1500,
    parameter int FRAME_US = 20000,
    parameter int OFS_US   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_gen,
    input  logic             i_boundary,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_we_l,
    input  logic             i_we_h,
    input  logic             i_we_c,
    input  logic [7:0]       i_wdata,
    output logic [15:0]      o_shadow,
    output logic             o_ch_en,
    output logic             o_servo
);
    logic [7:0]       r_temp;
    logic [15:0]      r_shadow, r_act_w, r_pend_w;
    logic             r_ch_en, r_act_en, r_pend_en, r_pend, r_run, r_servo;
    logic [CNT_W:0]   w_diff;
    logic [CNT_W-1:0] w_rel;
    logic [15:0]      w_cw;
    logic             w_ce, w_on, w_safe, w_load;

    assign w_diff = {1'b0, i_cnt} - (CNT_W+1)'(OFS_US);
    assign w_rel  = w_diff[CNT_W] ? w_diff[CNT_W-1:0] + CNT_W'(FRAME_US) : w_diff[CNT_W-1:0];
    // r_run blocks a wrapped tail from showing before the channel's first rise after enable
    assign w_on   = r_act_en & (r_run | (w_rel == '0)) & (w_rel < r_act_w);
    assign w_cw   = i_boundary ? r_shadow : r_pend_w;
    assign w_ce   = i_boundary ? r_ch_en : r_pend_en;
    // a boundary load waits until neither the old nor the new pulse would be cut or started mid-way
    assign w_safe = !w_on & !(w_ce & (w_rel < w_cw));
    assign w_load = !i_gen | ((i_boundary | r_pend) & w_safe);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_temp    <= '0;
            r_shadow  <= 16'(RESET_US);
            r_ch_en   <= 1'b0;
            r_act_w   <= 16'(RESET_US);
            r_act_en  <= 1'b0;
            r_pend_w  <= 16'(RESET_US);
            r_pend_en <= 1'b0;
            r_pend    <= 1'b0;
            r_run     <= 1'b0;
            r_servo   <= 1'b0;
        end else begin
            if (i_we_l) r_temp <= i_wdata;
            if (i_we_h) r_shadow <= clamp({i_wdata, r_temp}, 16'(MIN_US), 16'(MAX_US));
            if (i_we_c) r_ch_en <= i_wdata[0];
            if (w_load) begin
                r_act_w  <= i_gen ? w_cw : r_shadow;
                r_act_en <= i_gen ? w_ce : r_ch_en;
            end
            if (i_boundary) begin
                r_pend_w  <= r_shadow;
                r_pend_en <= r_ch_en;
            end
            r_pend  <= i_gen & (i_boundary | r_pend) & !w_safe;
            r_run   <= i_gen & (r_run | (w_rel == '0));
            r_servo <= i_gen & w_on;
        end
    end

    assign o_shadow = r_shadow;
    assign o_ch_en  = r_ch_en;
    assign o_servo  = r_servo;
endmodule

// File: rtl/evo_servo_multi.sv
// evo_servo_multi: NUM_CH-channel RC-servo pulse generator on the OpenEvo XB CSR bus.
// Define EVO_SERVO_STAGGER_EN to spread channel rise points evenly over the first half of the frame.
module evo_servo_multi
    import evo_xb_addr_pkg::*;
    import evo_servo_multi_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter logic [11:0] BASE_ADDR    = EVO_SERVO_MULTI_ADDR,
    parameter int          CLK_FREQ_MHZ = 16,
    parameter int          FRAME_US     = 20000,
    parameter int          MIN_US       = 500,
    parameter int          MAX_US       = 2500,
    parameter int          RESET_US     = 1500
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [11:0]       csr_addr,
    input  logic              csr_wr,
    input  logic              csr_rd,
    input  logic [7:0]        csr_wdata,
    output logic [7:0]        csr_rdata,
    output logic              csr_hit,
    output logic [NUM_CH-1:0] servo_out,
    output logic              frame_irq
);
    localparam int PS_W = $clog2(CLK_FREQ_MHZ);
    localparam int WIN  = 2 + CH_STRIDE * NUM_CH;
`ifdef EVO_SERVO_STAGGER_EN
    localparam int STAGGER_US = FRAME_US / (2 * NUM_CH);
`else
    localparam int STAGGER_US = 0;
`endif

    logic [PS_W-1:0]   r_presc;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_ctrl;
    logic [11:0]       w_ofs;
    logic              w_in, w_gen, w_tick, w_boundary, w_ctrl_we;
    logic [7:0]        w_rmux;
    logic [15:0]       w_shadow [NUM_CH];
    logic [NUM_CH-1:0] w_ch_en;

    assign w_ofs      = csr_addr - BASE_ADDR;
    assign w_in       = (csr_addr >= BASE_ADDR) && (w_ofs < 12'(WIN));
    assign w_gen      = r_ctrl[CTRL_GEN];
    assign w_tick     = w_gen && (r_presc == PS_W'(CLK_FREQ_MHZ - 1));
    assign w_boundary = w_tick && (r_cnt == CNT_W'(FRAME_US - 1));
    assign w_ctrl_we  = csr_wr && w_in && (w_ofs == 12'(CTRL_OFS));
    assign frame_irq  = r_ctrl[CTRL_DONE] & r_ctrl[CTRL_IRQ_EN];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_cnt   <= '0;
        end else if (!w_gen) begin
            r_presc <= '0;
            r_cnt   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) r_cnt <= w_boundary ? '0 : r_cnt + 1'b1;
        end
    end

    // a boundary in the same cycle as a W1C keeps FRAME_DONE set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl <= '0;
        end else begin
            if (w_ctrl_we) begin
                r_ctrl[CTRL_GEN]    <= csr_wdata[CTRL_GEN];
                r_ctrl[CTRL_IRQ_EN] <= csr_wdata[CTRL_IRQ_EN];
            end
            r_ctrl[CTRL_DONE] <= w_boundary | (r_ctrl[CTRL_DONE] & !(w_ctrl_we & csr_wdata[CTRL_DONE]));
        end
    end

    always_comb begin
        w_rmux = '0;
        if (w_ofs == 12'(CTRL_OFS)) w_rmux = {5'b0, r_ctrl};
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_ofs == 12'(PW_L_OFS + CH_STRIDE * c)) w_rmux = w_shadow[c][7:0];
            if (w_ofs == 12'(PW_H_OFS + CH_STRIDE * c)) w_rmux = w_shadow[c][15:8];
            if (w_ofs == 12'(CH_CTRL_OFS + CH_STRIDE * c)) w_rmux = {7'b0, w_ch_en[c]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csr_rdata <= '0;
            csr_hit   <= 1'b0;
        end else begin
            csr_rdata <= (csr_rd && w_in) ? w_rmux : '0;
            csr_hit   <= (csr_wr || csr_rd) && w_in;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        evo_servo_chan #(
            .MIN_US   (MIN_US),
            .MAX_US   (MAX_US),
            .RESET_US (RESET_US),
            .FRAME_US (FRAME_US),
            .OFS_US   (STAGGER_US * g)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .i_gen      (w_gen),
            .i_boundary (w_boundary),
            .i_cnt      (r_cnt),
            .i_we_l     (csr_wr && w_in && (w_ofs == 12'(PW_L_OFS + CH_STRIDE * g))),
            .i_we_h     (csr_wr && w_in && (w_ofs == 12'(PW_H_OFS + CH_STRIDE * g))),
            .i_we_c     (csr_wr && w_in && (w_ofs == 12'(CH_CTRL_OFS + CH_STRIDE * g))),
            .i_wdata    (csr_wdata),
            .o_shadow   (w_shadow[g]),
            .o_ch_en    (w_ch_en[g]),
            .o_servo    (servo_out[g])
        );
    end
endmodule
